arm7tdmi_tap_controller: RTL
============================

Name: arm7tdmi_tap_controller

Overview:
IEEE 1149.1 TAP controller for the ARM7TDMI test port. It runs the 16-state TAP FSM from TMS and holds the instruction register, IDCODE register and BYPASS register. It generates the select, capture, shift, update and test-mode controls that the boundary scan chain consumes, and it muxes that chain's serial output onto TDO. It is the front end that drives the boundary scan cell chain.

Parameters:
IR_LENGTH, 4, instruction register width in bits.
IDCODE_VALUE, 32'h3F0F0F0F, device ID. Bit 0 must be 1.
IR_EXTEST, 4'b0000, EXTEST opcode.
IR_SAMPLE, 4'b0011, SAMPLE/PRELOAD opcode.
IR_INTEST, 4'b1100, INTEST opcode.
IR_IDCODE, 4'b1110, IDCODE opcode.
IR_BYPASS, 4'b1111, BYPASS opcode.

Ports:
tck  input  1  TAP clock. All state changes on the rising edge.
trst_n  input  1  TAP reset, asynchronous, active-low.
tms  input  1  test mode select.
tdi  input  1  serial data in.
tdo  output  1  serial data out (combinational mux).
tdo_en  output  1  high only in SHIFT_IR or SHIFT_DR.
bscan_tdo  input  1  serial output of the boundary scan chain.
bscan_select  output  1  current instruction is EXTEST, SAMPLE or INTEST.
capture_dr  output  1  FSM is in CAPTURE_DR.
shift_dr  output  1  FSM is in SHIFT_DR.
update_dr  output  1  FSM is in UPDATE_DR.
extest_mode  output  1  current instruction is EXTEST.
sample_mode  output  1  current instruction is SAMPLE.
test_mode  output  1  current instruction is EXTEST or INTEST.
ir_current  output  IR_LENGTH  active instruction.
tap_state  output  4  FSM state, for debug.

Behaviour:
- Clock is tck. Reset is trst_n, asynchronous and active-low.
- Reset values: state = TEST_LOGIC_RESET, ir_current = IR_IDCODE, IR shift register = 0, IDCODE and bypass shift registers = 0. All strobes and mode outputs are 0. tdo = 0, tdo_en = 0.
- State encoding and next state, written as (TMS=0 / TMS=1):
  - TLR 0xF: RTI / TLR
  - RTI 0xC: RTI / SEL_DR
  - SEL_DR 0x7: CAP_DR / SEL_IR
  - CAP_DR 0x6: SH_DR / EX1_DR
  - SH_DR 0x2: SH_DR / EX1_DR
  - EX1_DR 0x1: PA_DR / UPD_DR
  - PA_DR 0x3: PA_DR / EX2_DR
  - EX2_DR 0x0: SH_DR / UPD_DR
  - UPD_DR 0x5: RTI / SEL_DR
  - SEL_IR 0x4: CAP_IR / TLR
  - CAP_IR 0xE: SH_IR / EX1_IR
  - SH_IR 0xA: SH_IR / EX1_IR
  - EX1_IR 0x9: PA_IR / UPD_IR
  - PA_IR 0xB: PA_IR / EX2_IR
  - EX2_IR 0x8: SH_IR / UPD_IR
  - UPD_IR 0xD: RTI / SEL_DR
- Five consecutive TMS=1 edges reach TLR from any state.
- capture_dr, shift_dr and update_dr are combinational decodes of the state register. Each is high for exactly the cycles spent in its state, so the chain acts on the rising edge that leaves that state.
- IR path:
  - Rising edge in CAP_IR loads the IR shift register with {0…,01}.
  - Each rising edge in SH_IR shifts right, with tdi entering the MSB.
  - Rising edge in UPD_IR copies the IR shift register into ir_current.
  - While in TLR, ir_current is forced to IR_IDCODE synchronously.
  - An opcode not listed in Parameters behaves as BYPASS: bypass register selected, all mode outputs 0.
- DR path, selected by ir_current:
  - IDCODE: 32-bit register. Captures IDCODE_VALUE; shifts right with tdi entering the MSB.
  - BYPASS (and unlisted opcodes): 1-bit register. Captures 0; on shift, loads tdi.
  - EXTEST, SAMPLE, INTEST: this block holds no DR. tdo = bscan_tdo.
- tdo:
  - SH_IR: IR shift register LSB.
  - SH_DR: LSB of the selected DR.
  - All other states: 0.
  - No falling-edge retiming is done in this block.
- Mode outputs are pure decodes of ir_current. They change only on the edge that leaves UPD_IR, on entry to TLR, or on async reset.
- Reset mid-operation: trst_n low at any time immediately forces the reset values. Partially shifted IR/DR contents are discarded, and extest_mode drops in the same instant.
- Pause states (PA_*) hold all shift registers unchanged.

Test Plan:
- Assert trst_n=0, then release → tap_state=0xF, ir_current=4'b1110, all strobes/modes 0. From SH_DR, drive TMS=1 for 5 cycles → tap_state=0xF.
- From reset, drive TMS 0,1,0,0 then shift 32 cycles (TMS=1 on the last) → tdo sequence LSB-first equals 0x3F0F0F0F, and tdo_en is high for those 32 cycles.
- IR scan shifting in 4'b0000 → the first 4 tdo bits are 1,0,0,0. After UPD_IR, extest_mode=1, test_mode=1, bscan_select=1, and sample_mode=0.
- Load 4'b1111, then DR-scan tdi=1,0,1,1 → tdo=0,1,0,1, i.e. one-cycle delay with a leading captured 0.
- Load SAMPLE, DR scan of 8 bits → capture_dr high for 1 cycle, shift_dr for 8, update_dr for 1. tdo tracks bscan_tdo every shift cycle.
- Pull trst_n low during SH_IR after loading EXTEST → extest_mode=0, ir_current=1110 and tap_state=0xF asynchronously, before the next tck edge.

Source files
------------

// File: rtl/arm7tdmi_tap_controller.sv
// IEEE 1149.1 TAP controller for the ARM7TDMI test port: 16-state TAP FSM,
// instruction/IDCODE/BYPASS registers and boundary-scan control strobes.
module arm7tdmi_tap_controller #(
  parameter int unsigned              IR_LENGTH    = 4,
  parameter logic [31:0]              IDCODE_VALUE = 32'h3F0F0F0F,
  parameter logic [IR_LENGTH-1:0]     IR_EXTEST    = 4'b0000,
  parameter logic [IR_LENGTH-1:0]     IR_SAMPLE    = 4'b0011,
  parameter logic [IR_LENGTH-1:0]     IR_INTEST    = 4'b1100,
  parameter logic [IR_LENGTH-1:0]     IR_IDCODE    = 4'b1110,
  parameter logic [IR_LENGTH-1:0]     IR_BYPASS    = 4'b1111
) (
  input  logic                 tck,
  input  logic                 trst_n,
  input  logic                 tms,
  input  logic                 tdi,
  output logic                 tdo,
  output logic                 tdo_en,
  input  logic                 bscan_tdo,
  output logic                 bscan_select,
  output logic                 capture_dr,
  output logic                 shift_dr,
  output logic                 update_dr,
  output logic                 extest_mode,
  output logic                 sample_mode,
  output logic                 test_mode,
  output logic [IR_LENGTH-1:0] ir_current,
  output logic [3:0]           tap_state
);

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PA_DR  = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PA_IR  = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } state_e;

  state_e                 state_q, state_d;
  logic [IR_LENGTH-1:0]   ir_sr_q;
  logic [IR_LENGTH-1:0]   ir_current_q;
  logic [31:0]            idcode_sr_q;
  logic                   bypass_q;

  logic is_extest, is_sample, is_intest, is_idcode, is_bscan, is_bypass;

  assign is_extest = (ir_current_q == IR_EXTEST);
  assign is_sample = (ir_current_q == IR_SAMPLE);
  assign is_intest = (ir_current_q == IR_INTEST);
  assign is_idcode = (ir_current_q == IR_IDCODE);
  assign is_bscan  = is_extest | is_sample | is_intest;
  // BYPASS and every unlisted opcode select the 1-bit bypass register
  assign is_bypass = !is_bscan && !is_idcode;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PA_DR;
      PA_DR:  state_d = tms ? EX2_DR : PA_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PA_IR;
      PA_IR:  state_d = tms ? EX2_IR : PA_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q      <= TLR;
      ir_sr_q      <= '0;
      ir_current_q <= IR_IDCODE;
      idcode_sr_q  <= '0;
      bypass_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        CAP_IR: ir_sr_q <= IR_LENGTH'(1);
        SH_IR:  ir_sr_q <= {tdi, ir_sr_q[IR_LENGTH-1:1]};
        UPD_IR: ir_current_q <= ir_sr_q;
        CAP_DR: begin
          if (is_idcode)      idcode_sr_q <= IDCODE_VALUE;
          else if (is_bypass) bypass_q    <= 1'b0;
        end
        SH_DR: begin
          if (is_idcode)      idcode_sr_q <= {tdi, idcode_sr_q[31:1]};
          else if (is_bypass) bypass_q    <= tdi;
        end
        default: ;
      endcase
      // Forcing on the next-state lets the modes drop on the edge that enters TLR
      if (state_d == TLR) ir_current_q <= IR_IDCODE;
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state_q == SH_IR) begin
      tdo = ir_sr_q[0];
    end else if (state_q == SH_DR) begin
      if (is_bscan)       tdo = bscan_tdo;
      else if (is_idcode) tdo = idcode_sr_q[0];
      else                tdo = bypass_q;
    end
  end

  assign tdo_en       = (state_q == SH_IR) || (state_q == SH_DR);
  assign capture_dr   = (state_q == CAP_DR);
  assign shift_dr     = (state_q == SH_DR);
  assign update_dr    = (state_q == UPD_DR);
  assign bscan_select = is_bscan;
  assign extest_mode  = is_extest;
  assign sample_mode  = is_sample;
  assign test_mode    = is_extest | is_intest;
  assign ir_current   = ir_current_q;
  assign tap_state    = state_q;

endmodule
